mem_access_stage: RTL and testbench

//  MEM-stage access controller. It sits directly downstream of the EX/MEM pipeline register.
//  It takes the registered memory op, address and store data, and runs the data-memory handshake.

---
 rtl/mem_access_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access controller.
// Runs the dmem request/response handshake for word and byte loads and stores,
// the indirect LDI/STI double access and the TRAP vector read. While a sequence
// is in flight it stalls the upstream pipeline registers.
module mem_access_stage #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  mem_op,
    input  logic [15:0] addr_in,
    input  logic [15:0] sdata_in,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_wmask,
    output logic [15:0] dmem_wdata,
    output logic [15:0] mem_data_out,
    output logic        done,
    output logic        stall_out,
    output logic        err_timeout
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LDR   = 3'd1;
    localparam logic [2:0] OP_STR   = 3'd2;
    localparam logic [2:0] OP_LDB   = 3'd3;
    localparam logic [2:0] OP_STB   = 3'd4;
    localparam logic [2:0] OP_LDI   = 3'd5;
    localparam logic [2:0] OP_STI   = 3'd6;
    localparam logic [2:0] OP_TRAPV = 3'd7;

    localparam logic [8:0] WAIT_LIMIT_W = 9'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic        addr_lsb_reg;
    logic [15:0] sdata_reg;
    logic [7:0]  wait_cnt_reg;

    logic        accept;
    logic        in_is_store;
    logic [1:0]  in_wmask;
    logic [15:0] in_wdata;
    logic        op_is_indirect;
    logic [15:0] load_value;
    logic [8:0]  wait_inc;
    logic        limit_hit;

    // Decode of the incoming request that sets up the first access.
    always_comb begin
        accept      = (state_reg == IDLE) && req_valid && (mem_op != OP_NONE);
        in_is_store = (mem_op == OP_STR) || (mem_op == OP_STB);
        in_wmask    = 2'b11;
        in_wdata    = 16'h0000;
        if (mem_op == OP_STB) begin
            in_wmask = addr_in[0] ? 2'b10 : 2'b01;
            in_wdata = {sdata_in[7:0], sdata_in[7:0]};
        end else if (mem_op == OP_STR) begin
            in_wdata = sdata_in;
        end
    end

    // Load result formatting and wait-counter bookkeeping for the latched op.
    always_comb begin
        op_is_indirect = (op_reg == OP_LDI) || (op_reg == OP_STI);
        load_value     = 16'h0000;
        case (op_reg)
            OP_LDR, OP_TRAPV: load_value = dmem_rdata;
            OP_LDB:           load_value = {8'h00, addr_lsb_reg ? dmem_rdata[15:8] : dmem_rdata[7:0]};
            default:          load_value = 16'h0000;
        endcase
        wait_inc  = {1'b0, wait_cnt_reg} + 9'd1;
        limit_hit = (wait_inc >= WAIT_LIMIT_W);
    end

    // Stall is combinational so the accept cycle already freezes upstream.
    always_comb begin
        stall_out = accept || (state_reg == ACC1) || (state_reg == ACC2);
    end

    // Access sequencer: request registers, result capture and timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= OP_NONE;
            addr_lsb_reg <= 1'b0;
            sdata_reg    <= 16'h0000;
            wait_cnt_reg <= 8'd0;
            dmem_address <= 16'h0000;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_wmask   <= 2'b00;
            dmem_wdata   <= 16'h0000;
            mem_data_out <= 16'h0000;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        op_reg       <= mem_op;
                        addr_lsb_reg <= addr_in[0];
                        sdata_reg    <= sdata_in;
                        dmem_address <= {addr_in[15:1], 1'b0};
                        dmem_read    <= !in_is_store;
                        dmem_write   <= in_is_store;
                        dmem_wmask   <= in_wmask;
                        dmem_wdata   <= in_wdata;
                        wait_cnt_reg <= 8'd0;
                        state_reg    <= ACC1;
                    end
                end
                ACC1: begin
                    if (dmem_resp) begin
                        if (op_is_indirect) begin
                            // First access fetched the pointer; retarget at it.
                            dmem_address <= {dmem_rdata[15:1], 1'b0};
                            dmem_read    <= (op_reg == OP_LDI);
                            dmem_write   <= (op_reg == OP_STI);
                            dmem_wmask   <= 2'b11;
                            dmem_wdata   <= (op_reg == OP_STI) ? sdata_reg : 16'h0000;
                            wait_cnt_reg <= 8'd0;
                            state_reg    <= ACC2;
                        end else begin
                            dmem_read    <= 1'b0;
                            dmem_write   <= 1'b0;
                            mem_data_out <= load_value;
                            done         <= 1'b1;
                            state_reg    <= DONE;
                        end
                    end else begin
                        if (wait_cnt_reg != 8'hFF) wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        if (limit_hit) err_timeout <= 1'b1;
                    end
                end
                ACC2: begin
                    if (dmem_resp) begin
                        dmem_read    <= 1'b0;
                        dmem_write   <= 1'b0;
                        mem_data_out <= (op_reg == OP_LDI) ? dmem_rdata : 16'h0000;
                        done         <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        if (wait_cnt_reg != 8'hFF) wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        if (limit_hit) err_timeout <= 1'b1;
                    end
                end
                default: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench for mem_access_stage (WAIT_LIMIT=4).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  mem_op;
    logic [15:0] addr_in;
    logic [15:0] sdata_in;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_wmask;
    logic [15:0] dmem_wdata;
    logic [15:0] mem_data_out;
    logic        done;
    logic        stall_out;
    logic        err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_op(mem_op),
        .addr_in(addr_in), .sdata_in(sdata_in), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dmem_address(dmem_address), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .mem_data_out(mem_data_out), .done(done), .stall_out(stall_out),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; mem_op = 3'd0; addr_in = 16'h0;
        sdata_in = 16'h0; dmem_rdata = 16'h0; dmem_resp = 1'b0;
        #3;
        n_cmp++; if ({dmem_read, dmem_write, dmem_wmask} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_req got r%b w%b m%b exp 0/0/00", dmem_read, dmem_write, dmem_wmask); end
        n_cmp++; if ({dmem_address, dmem_wdata, mem_data_out} !== 48'h0) begin n_bad++;
            $display("FAIL reset_data got a%h w%h d%h exp 0", dmem_address, dmem_wdata, mem_data_out); end
        n_cmp++; if ({done, stall_out, err_timeout} !== 3'b000) begin n_bad++;
            $display("FAIL reset_flags got done%b stall%b err%b exp 000", done, stall_out, err_timeout); end
        next_cycle(); next_cycle();
        reset = 1'b0;
        next_cycle();
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++;
            $display("FAIL idle_stall got %b exp 0", stall_out); end
        $display("test_reset done");
    endtask

    task automatic test_ldr();
        next_cycle();  // cycle 0: present LDR
        req_valid = 1'b1; mem_op = 3'd1; addr_in = 16'h1003; dmem_resp = 1'b0;
        #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++;
            $display("FAIL ldr_accept_stall got %b exp 1", stall_out); end
        next_cycle();  // cycle 1: ACC1, no resp; op changes must be ignored
        n_cmp++; if ({dmem_read, dmem_write, dmem_address} !== {2'b10, 16'h1002}) begin n_bad++;
            $display("FAIL ldr_c1 got r%b w%b a%h exp r1 w0 a1002", dmem_read, dmem_write, dmem_address); end
        mem_op = 3'd2; addr_in = 16'hFFFF;
        next_cycle();  // cycle 2: still waiting, resp now
        n_cmp++; if ({dmem_read, dmem_address, stall_out, done} !== {1'b1, 16'h1002, 2'b10}) begin n_bad++;
            $display("FAIL ldr_c2 got r%b a%h s%b d%b exp r1 a1002 s1 d0", dmem_read, dmem_address, stall_out, done); end
        dmem_resp = 1'b1; dmem_rdata = 16'hBEEF;
        next_cycle();  // cycle 3: DONE
        n_cmp++; if ({done, stall_out, dmem_read, mem_data_out} !== {3'b100, 16'hBEEF}) begin n_bad++;
            $display("FAIL ldr_done got d%b s%b r%b data%h exp d1 s0 r0 beef", done, stall_out, dmem_read, mem_data_out); end
        dmem_resp = 1'b0; req_valid = 1'b0; mem_op = 3'd0;
        next_cycle();
        n_cmp++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL ldr_done_pulse got %b exp 0", done); end
        $display("test_ldr done");
    endtask

    task automatic test_stb();
        next_cycle();
        req_valid = 1'b1; mem_op = 3'd4; addr_in = 16'h2001; sdata_in = 16'h00A5;
        next_cycle();  // ACC1
        n_cmp++; if ({dmem_write, dmem_read, dmem_wmask, dmem_wdata} !== {2'b10, 2'b10, 16'hA5A5}) begin n_bad++;
            $display("FAIL stb_req got w%b r%b m%b wd%h exp w1 r0 m10 a5a5", dmem_write, dmem_read, dmem_wmask, dmem_wdata); end
        dmem_resp = 1'b1; dmem_rdata = 16'h9999;
        next_cycle();  // DONE
        n_cmp++; if ({done, dmem_write, mem_data_out} !== {2'b10, 16'h0000}) begin n_bad++;
            $display("FAIL stb_done got d%b w%b data%h exp d1 w0 0000", done, dmem_write, mem_data_out); end
        dmem_resp = 1'b0; req_valid = 1'b0; mem_op = 3'd0;
        $display("test_stb done");
    endtask

    task automatic test_ldi();
        next_cycle();
        req_valid = 1'b1; mem_op = 3'd5; addr_in = 16'h3000;
        next_cycle();  // ACC1
        n_cmp++; if ({dmem_read, dmem_address} !== {1'b1, 16'h3000}) begin n_bad++;
            $display("FAIL ldi_acc1 got r%b a%h exp r1 a3000", dmem_read, dmem_address); end
        dmem_resp = 1'b1; dmem_rdata = 16'h4000;
        next_cycle();  // ACC2
        n_cmp++; if ({dmem_read, dmem_address, stall_out, done} !== {1'b1, 16'h4000, 2'b10}) begin n_bad++;
            $display("FAIL ldi_acc2 got r%b a%h s%b d%b exp r1 a4000 s1 d0", dmem_read, dmem_address, stall_out, done); end
        dmem_rdata = 16'h1234;
        next_cycle();  // DONE
        n_cmp++; if ({done, mem_data_out} !== {1'b1, 16'h1234}) begin n_bad++;
            $display("FAIL ldi_done got d%b data%h exp d1 1234", done, mem_data_out); end
        dmem_resp = 1'b0; req_valid = 1'b0; mem_op = 3'd0;
        next_cycle();
        n_cmp++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL ldi_done_once got %b exp 0", done); end
        $display("test_ldi done");
    endtask

    task automatic test_sti();
        next_cycle();
        req_valid = 1'b1; mem_op = 3'd6; addr_in = 16'h3000; sdata_in = 16'h00FF;
        next_cycle();  // ACC1: pointer read
        n_cmp++; if ({dmem_read, dmem_write, dmem_address, stall_out} !== {2'b10, 16'h3000, 1'b1}) begin n_bad++;
            $display("FAIL sti_acc1 got r%b w%b a%h s%b exp r1 w0 a3000 s1", dmem_read, dmem_write, dmem_address, stall_out); end
        dmem_resp = 1'b1; dmem_rdata = 16'h5000;
        next_cycle();  // ACC2, no resp this cycle
        n_cmp++; if ({dmem_write, dmem_read, dmem_address, dmem_wmask, dmem_wdata} !== {2'b10, 16'h5000, 2'b11, 16'h00FF}) begin n_bad++;
            $display("FAIL sti_acc2 got w%b r%b a%h m%b wd%h exp w1 r0 a5000 m11 00ff", dmem_write, dmem_read, dmem_address, dmem_wmask, dmem_wdata); end
        dmem_resp = 1'b0;
        next_cycle();  // still ACC2
        n_cmp++; if ({stall_out, dmem_write, done} !== 3'b110) begin n_bad++;
            $display("FAIL sti_hold got s%b w%b d%b exp s1 w1 d0", stall_out, dmem_write, done); end
        dmem_resp = 1'b1;
        next_cycle();  // DONE
        n_cmp++; if ({done, stall_out, dmem_write, mem_data_out} !== {3'b100, 16'h0000}) begin n_bad++;
            $display("FAIL sti_done got d%b s%b w%b data%h exp d1 s0 w0 0000", done, stall_out, dmem_write, mem_data_out); end
        dmem_resp = 1'b0; req_valid = 1'b0; mem_op = 3'd0;
        $display("test_sti done");
    endtask

    task automatic test_back_to_back();
        next_cycle();
        req_valid = 1'b1; mem_op = 3'd3; addr_in = 16'h0101;
        next_cycle();  // ACC1, resp immediately
        dmem_resp = 1'b1; dmem_rdata = 16'hAB12;
        next_cycle();  // DONE at cycle 2; next request presented now
        n_cmp++; if ({done, stall_out, mem_data_out} !== {2'b10, 16'h00AB}) begin n_bad++;
            $display("FAIL ldb_done got d%b s%b data%h exp d1 s0 00ab", done, stall_out, mem_data_out); end
        dmem_resp = 1'b1; mem_op = 3'd7; addr_in = 16'h0025; dmem_rdata = 16'h5555;
        next_cycle();  // IDLE: resp ignored, request accepted
        n_cmp++; if ({done, stall_out, dmem_read} !== 3'b010) begin n_bad++;
            $display("FAIL b2b_idle got d%b s%b r%b exp d0 s1 r0", done, stall_out, dmem_read); end
        dmem_resp = 1'b0;
        next_cycle();  // ACC1 for TRAPV
        n_cmp++; if ({dmem_read, dmem_address} !== {1'b1, 16'h0024}) begin n_bad++;
            $display("FAIL trapv_req got r%b a%h exp r1 a0024", dmem_read, dmem_address); end
        dmem_resp = 1'b1; dmem_rdata = 16'h3000;
        next_cycle();
        n_cmp++; if ({done, mem_data_out} !== {1'b1, 16'h3000}) begin n_bad++;
            $display("FAIL trapv_done got d%b data%h exp d1 3000", done, mem_data_out); end
        dmem_resp = 1'b0; req_valid = 1'b0; mem_op = 3'd0;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        next_cycle();
        req_valid = 1'b1; mem_op = 3'd5; addr_in = 16'h3000;
        next_cycle();  // ACC1
        dmem_resp = 1'b1; dmem_rdata = 16'h4000;
        next_cycle();  // ACC2 with read pending
        dmem_resp = 1'b0; req_valid = 1'b0; mem_op = 3'd0;
        reset = 1'b1;
        #1;
        n_cmp++; if ({dmem_read, dmem_write, stall_out} !== 3'b000) begin n_bad++;
            $display("FAIL rst_mid_drop got r%b w%b s%b exp 000", dmem_read, dmem_write, stall_out); end
        next_cycle();
        reset = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h7E7E;
        next_cycle();  // late resp lands in IDLE
        n_cmp++; if ({done, dmem_read, dmem_write, mem_data_out} !== {3'b000, 16'h0000}) begin n_bad++;
            $display("FAIL rst_mid_late got d%b r%b w%b data%h exp 0 0 0 0000", done, dmem_read, dmem_write, mem_data_out); end
        dmem_resp = 1'b0;
        next_cycle();
        n_cmp++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL rst_mid_nodone got %b exp 0", done); end
        $display("test_reset_mid done");
    endtask

    task automatic test_timeout();
        next_cycle();
        req_valid = 1'b1; mem_op = 3'd1; addr_in = 16'h0010;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();  // ACC1 wait cycle c
            if (c == 4) begin
                n_cmp++; if (err_timeout !== 1'b0) begin n_bad++;
                    $display("FAIL timeout_early got %b exp 0 at wait %0d", err_timeout, c); end
            end
            if (c >= 5) begin
                n_cmp++; if ({err_timeout, dmem_read} !== 2'b11) begin n_bad++;
                    $display("FAIL timeout_set got err%b r%b exp 1 1 at wait %0d", err_timeout, dmem_read, c); end
            end
        end
        next_cycle();  // wait cycle 7: late resp
        dmem_resp = 1'b1; dmem_rdata = 16'h7777;
        next_cycle();
        n_cmp++; if ({done, mem_data_out, err_timeout} !== {1'b1, 16'h7777, 1'b1}) begin n_bad++;
            $display("FAIL timeout_late got d%b data%h err%b exp d1 7777 err1", done, mem_data_out, err_timeout); end
        dmem_resp = 1'b0; req_valid = 1'b0; mem_op = 3'd0;
        next_cycle(); next_cycle();
        n_cmp++; if (err_timeout !== 1'b1) begin n_bad++;
            $display("FAIL timeout_sticky got %b exp 1", err_timeout); end
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_stb();
        test_ldi();
        test_sti();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
